demux64_reg: RTL and testbench
==============================

# demux64_reg

Write-side counterpart of the 64-way read multiplexer: a 1-to-64 demultiplexing register bank that steers one `size`-bit word into one of 64 output registers per accepted write. It has a valid/ready write handshake and a sequential clear sweep that zeroes all 64 entries, one per cycle. It sits in front of any 64-entry store whose outputs feed the 64:1 read mux.

## Interface
- `size`, 64, data width of each entry.
- `clk` input 1, single clock, all state updates on rising edge.
- `reset` input 1, synchronous, active-high.
- `wr_valid` input 1, write request.
- `wr_ready` output 1, block accepts a write this cycle.
- `wr_sel` input 6, destination entry index 0..63.
- `wr_data` input `size`, word to store.
- `clr_req` input 1, request a full clear sweep.
- `busy` output 1, clear sweep in progress.
- `q` output 64*`size`, packed entries; entry k occupies bits [k*size +: size].
- `wr_count` output 16, accepted-write counter (present only with `DEMUX64_WRCOUNT_EN`).

## Operation
- States: IDLE, CLEAR. Reset state IDLE.
- Reset values: all `q` entries 0, clear index 0, `busy`=0, `wr_count`=0. `wr_ready`=0 while `reset` is high.
- IDLE: `wr_ready`=1 (combinational, `state==IDLE && !reset`). Write accepted when `wr_valid && wr_ready`; entry `wr_sel` loads `wr_data` at that edge; other entries hold.
- IDLE with `clr_req`=1: next state CLEAR, clear index 0. A write presented in the same cycle is still accepted, then zeroed by the sweep.
- CLEAR: `busy`=1, `wr_ready`=0, `wr_valid` ignored. Each cycle entry[clear index] becomes 0 and the index increments. The cycle with index 63 clears entry 63 and returns to IDLE; the index wraps to 0.
- `clr_req` is sampled only in IDLE; held or re-asserted during CLEAR it has no effect. If still high on the first IDLE cycle, a new sweep starts.
- `reset` mid-sweep: abort to IDLE. All entries become 0.
- `wr_sel` is always in range (6 bits, 64 entries), so no out-of-range handling.

## Timing
- Write latency: 1 cycle. A word accepted at edge N is visible on `q` after edge N.
- Throughput: 1 write per cycle in IDLE.
- Clear: `busy` is high for exactly 64 cycles. `wr_ready` returns 1 on the 65th cycle after the `clr_req` acceptance edge.
- Entry k reads 0 from the (k+1)th edge after CLEAR entry.

## Configuration
- `DEMUX64_WRCOUNT_EN` defined:
  - Adds the `wr_count` port.
  - Counts accepted handshake writes, saturating at 16'hFFFF.
  - Sweep zeroing is not counted.
  - Cleared only by `reset`.
- Not defined: no `wr_count` port and no counter logic. All other behaviour is identical.

## Structure
- Package `demux64_pkg`:
  - `state_t` enum {IDLE, CLEAR}.
  - `NUM_ENTRIES`=64.
  - `SEL_W`=6.
- Sub-module `dec6to64`: combinational 6-bit to one-hot 64-bit decoder with an enable input. It generates the per-entry load strobe for handshake writes. The top selects between the handshake index and the clear index.

## Test plan
- Reset, then write `wr_sel`=5, `wr_data`=64'hDEAD_BEEF -> after 1 edge, entry 5 = DEAD_BEEF, all other entries 0, `wr_count`=1.
- Back-to-back writes: entry 0 = 1, entry 63 = 2, entry 0 = 3 on consecutive cycles -> entry 0 = 3, entry 63 = 2, `wr_count`=3.
- Fill all 64 entries, pulse `clr_req` -> `busy` high 64 cycles, `wr_ready` low throughout, entry k zero after the (k+1)th edge, `wr_ready`=1 on cycle 65.
- `clr_req` and write (sel 9, data 7) in the same IDLE cycle -> write accepted, entry 9 = 7 until sweep index 9 zeroes it; `wr_count`=1.
- `wr_valid` held during CLEAR -> no entry written, `wr_count` unchanged.
- `reset` asserted at sweep index 30 -> next edge: IDLE, `busy`=0, all entries 0. Writes resume the cycle after `reset` drops.

Source files
------------

// File: rtl/demux64_pkg.sv
// Shared types and constants for the 64-entry demultiplexing register bank.
package demux64_pkg;

  localparam int NUM_ENTRIES = 64;
  localparam int SEL_W       = 6;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  function automatic logic is_last_index(input logic [SEL_W-1:0] idx);
    return idx == SEL_W'(NUM_ENTRIES - 1);
  endfunction

endpackage

// File: rtl/dec6to64.sv
// Enabled 6-to-64 one-hot decoder producing per-entry load strobes.
module dec6to64
  import demux64_pkg::*;
(
  input  logic                   en_i,
  input  logic [SEL_W-1:0]       sel_i,
  output logic [NUM_ENTRIES-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[sel_i] = 1'b1;
    end
  end

endmodule

// File: rtl/demux64_reg.sv
// 1-to-64 demultiplexing register bank with valid/ready writes and a clear sweep.
// Optional accepted-write counter enabled by defining DEMUX64_WRCOUNT_EN.
module demux64_reg
  import demux64_pkg::*;
#(
  parameter int size = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [SEL_W-1:0]            wr_sel,
  input  logic [size-1:0]             wr_data,
  input  logic                        clr_req,
  output logic                        busy,
  output logic [NUM_ENTRIES*size-1:0] q
`ifdef DEMUX64_WRCOUNT_EN
  ,
  output logic [15:0]                 wr_count
`endif
);

  state_t                 state_q, state_d;
  logic [SEL_W-1:0]       clr_idx_q, clr_idx_d;
  logic [size-1:0]        entry_q [NUM_ENTRIES];

  logic                   wr_accept;
  logic                   ld_en;
  logic [SEL_W-1:0]       ld_sel;
  logic [size-1:0]        ld_data;
  logic [NUM_ENTRIES-1:0] ld_strobe;

  assign wr_ready  = (state_q == IDLE) && !reset;
  assign busy      = (state_q == CLEAR);
  assign wr_accept = wr_valid && wr_ready;

  // One shared load port: the sweep owns it while clearing, the handshake otherwise.
  assign ld_en   = busy || wr_accept;
  assign ld_sel  = busy ? clr_idx_q : wr_sel;
  assign ld_data = busy ? '0 : wr_data;

  dec6to64 u_dec (
    .en_i     (ld_en),
    .sel_i    (ld_sel),
    .onehot_o (ld_strobe)
  );

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end
      end
      CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (is_last_index(clr_idx_q)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        clr_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_ENTRIES; k++) begin
        entry_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_ENTRIES; k++) begin
        if (ld_strobe[k]) begin
          entry_q[k] <= ld_data;
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_ENTRIES; k++) begin : g_q
    assign q[k*size +: size] = entry_q[k];
  end

`ifdef DEMUX64_WRCOUNT_EN
  logic [15:0] wr_count_q, wr_count_d;

  // Saturates rather than wraps so a long-running count never looks small.
  always_comb begin
    wr_count_d = wr_count_q;
    if (wr_accept && (wr_count_q != 16'hFFFF)) begin
      wr_count_d = wr_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_count_q <= '0;
    end else begin
      wr_count_q <= wr_count_d;
    end
  end

  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_demux64_reg.sv
// Self-checking bench for demux64_reg: vector table, directed sweep cases, random traffic.
module tb_demux64_reg;

  localparam int SIZE = 64;
  localparam int N    = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic            wr_valid;
  logic            wr_ready;
  logic [5:0]      wr_sel;
  logic [SIZE-1:0] wr_data;
  logic            clr_req;
  logic            busy;
  logic [N*SIZE-1:0] q;
`ifdef DEMUX64_WRCOUNT_EN
  logic [15:0]     wr_count;
`endif

  always #5 clk = ~clk;

  demux64_reg #(.size(SIZE)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .clr_req  (clr_req),
    .busy     (busy),
    .q        (q)
`ifdef DEMUX64_WRCOUNT_EN
    ,
    .wr_count (wr_count)
`endif
  );

  // Reference model: entry contents, sweep position (-1 when not sweeping), write count.
  logic [SIZE-1:0] model [N];
  int              sweepPos;
  int unsigned     modelCount;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit              rst;
    bit              valid;
    bit [5:0]        sel;
    logic [SIZE-1:0] data;
    bit              clr;
    bit [5:0]        chkSel;
    logic [SIZE-1:0] expData;
    bit              expReady;
    bit              expBusy;
  } vec_t;

  vec_t vecs[7];

  task automatic compareBit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareWord(input string name, input logic [SIZE-1:0] act, input logic [SIZE-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic valid, input logic [5:0] sel,
                               input logic [SIZE-1:0] data, input logic clr);
    reset    = rst;
    wr_valid = valid;
    wr_sel   = sel;
    wr_data  = data;
    clr_req  = clr;
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < N; k++) model[k] = '0;
      sweepPos   = -1;
      modelCount = 0;
    end else if (sweepPos < 0) begin
      if (valid) begin
        model[sel] = data;
        if (modelCount < 65535) modelCount++;
      end
      if (clr) sweepPos = 0;
    end else begin
      model[sweepPos] = '0;
      sweepPos++;
      if (sweepPos == N) sweepPos = -1;
    end
    #1;
  endtask

  task automatic checkOutput();
    int firstBad;
    firstBad = -1;
    compareBit("ready", wr_ready, (sweepPos < 0) && !reset);
    compareBit("busy", busy, sweepPos >= 0);
    total++;
    for (int k = N - 1; k >= 0; k--) begin
      if (q[k*SIZE +: SIZE] !== model[k]) firstBad = k;
    end
    if (firstBad >= 0) begin
      bad++;
      $display("[TB] FAIL entries: entry %0d got %0h expected %0h at %0t",
               firstBad, q[firstBad*SIZE +: SIZE], model[firstBad], $time);
    end
`ifdef DEMUX64_WRCOUNT_EN
    compareWord("wr_count", SIZE'(wr_count), SIZE'(modelCount));
`endif
  endtask

  function automatic logic [SIZE-1:0] rndWord();
    return {$urandom(), $urandom()} | 64'h1;
  endfunction

  task automatic fillAll();
    for (int k = 0; k < N; k++) begin
      applyStimulus(1'b0, 1'b1, 6'(k), rndWord(), 1'b0);
    end
    checkOutput();
  endtask

  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_sel = '0; wr_data = '0; clr_req = 1'b0;
    sweepPos = -1; modelCount = 0;
    for (int k = 0; k < N; k++) model[k] = '0;

    vecs[0] = '{1'b1, 1'b0, 6'd0,  64'h0,         1'b0, 6'd5,  64'h0,         1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 6'd5,  64'hDEAD_BEEF, 1'b0, 6'd5,  64'hDEAD_BEEF, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 6'd0,  64'h1,         1'b0, 6'd0,  64'h1,         1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 6'd63, 64'h2,         1'b0, 6'd63, 64'h2,         1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 6'd0,  64'h3,         1'b0, 6'd0,  64'h3,         1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 6'd0,  64'h0,         1'b0, 6'd63, 64'h2,         1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 6'd7,  64'h99,        1'b0, 6'd7,  64'h0,         1'b1, 1'b0};

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].sel, vecs[i].data, vecs[i].clr);
      compareWord("vec entry", q[vecs[i].chkSel*SIZE +: SIZE], vecs[i].expData);
      compareBit("vec ready", wr_ready, vecs[i].expReady);
      compareBit("vec busy", busy, vecs[i].expBusy);
      checkOutput();
    end

    // Full sweep with writes held and clr_req held early: nothing but zeroing happens.
    fillAll();
    applyStimulus(1'b0, 1'b0, 6'd0, '0, 1'b1);
    compareBit("sweep start busy", busy, 1'b1);
    for (int e = 1; e <= N; e++) begin
      applyStimulus(1'b0, 1'b1, 6'($urandom_range(63)), rndWord(), e < 10);
      compareWord("sweep entry zeroed", q[(e-1)*SIZE +: SIZE], '0);
      compareBit("sweep busy", busy, e < N);
      compareBit("sweep ready", wr_ready, e == N);
      checkOutput();
    end

    // Write and clear request in the same cycle.
    applyStimulus(1'b0, 1'b1, 6'd9, 64'h7, 1'b1);
    compareWord("same-cycle write", q[9*SIZE +: SIZE], 64'h7);
    for (int e = 1; e <= N; e++) begin
      applyStimulus(1'b0, 1'b0, 6'd0, '0, 1'b0);
      if (e == 9)  compareWord("entry9 before zero", q[9*SIZE +: SIZE], 64'h7);
      if (e == 10) compareWord("entry9 zeroed", q[9*SIZE +: SIZE], '0);
      checkOutput();
    end

    // Reset mid-sweep at index 30.
    fillAll();
    applyStimulus(1'b0, 1'b0, 6'd0, '0, 1'b1);
    for (int e = 0; e < 30; e++) applyStimulus(1'b0, 1'b0, 6'd0, '0, 1'b0);
    checkOutput();
    applyStimulus(1'b1, 1'b1, 6'd3, 64'h44, 1'b0);
    compareBit("reset abort busy", busy, 1'b0);
    compareWord("reset abort entry31", q[31*SIZE +: SIZE], '0);
    checkOutput();
    reset = 1'b0; wr_valid = 1'b1; wr_sel = 6'd12; wr_data = 64'h55;
    #1;
    compareBit("ready after reset drop", wr_ready, 1'b1);
    applyStimulus(1'b0, 1'b1, 6'd12, 64'h55, 1'b0);
    compareWord("write after reset", q[12*SIZE +: SIZE], 64'h55);
    checkOutput();

    // Random traffic with occasional clears and resets.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(99) == 0, $urandom_range(3) != 0,
                    6'($urandom_range(63)), rndWord(), $urandom_range(39) == 0);
      checkOutput();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
